// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request-capture block.
//   N_REQ      : number of request lines (fixed at 4 by the downstream encoder)
//   CODE_W     : width of an encoded request id
//   irq_state_e: handshake FSM states; the unused code 2'b11 falls back to idle
package irq_pkg;

   localparam int N_REQ  = 4;
   localparam int CODE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ASSERT  = 2'b01,
      ST_HOLDOFF = 2'b10
   } irq_state_e;

   // One-hot select of the request line named by an encoded id.
   function automatic logic [N_REQ-1:0] id_onehot(input logic [CODE_W-1:0] id);
      id_onehot     = '0;
      id_onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Single-bit synchroniser followed by a rising-edge detector.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_async        : asynchronous input
//   o_rise         : one-cycle pulse when the synchronised input goes 0->1
// History resets to 0, so an input already high at reset release is
// reported as a fresh edge.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign o_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_pending_4.sv
// Request-capture stage feeding an external 4-to-2 priority encoder.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req[3:0]              : asynchronous request lines (rising edge = event)
//   i_mask[3:0]             : hides a pending bit from the encoder only
//   o_code_req[3:0]         : pending & ~mask, to the encoder input
//   i_enc_code, i_enc_valid : encoder result, sampled in the same cycle
//   o_irq, o_irq_id         : interrupt and the id being serviced
//   i_ack                   : consumer acknowledge pulse
//   o_pending, o_overrun    : raw pending bits, sticky overrun flags
//   i_ovr_clr               : clears all overrun flags
module irq_pending_4
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_REQ-1:0]  i_req,
   input  logic [N_REQ-1:0]  i_mask,
   output logic [N_REQ-1:0]  o_code_req,
   input  logic [CODE_W-1:0] i_enc_code,
   input  logic              i_enc_valid,
   output logic              o_irq,
   output logic [CODE_W-1:0] o_irq_id,
   input  logic              i_ack,
   output logic [N_REQ-1:0]  o_pending,
   output logic [N_REQ-1:0]  o_overrun,
   input  logic              i_ovr_clr
);

   logic [N_REQ-1:0]  rise;
   logic [N_REQ-1:0]  clear;
   logic [N_REQ-1:0]  pending_q, pending_d;
   logic [N_REQ-1:0]  overrun_q, overrun_d;
   logic [CODE_W-1:0] irq_id_q, irq_id_d;
   irq_state_e        state_q, state_d;

   for (genvar k = 0; k < N_REQ; k++) begin : g_req
      sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_async (i_req[k]),
         .o_rise  (rise[k])
      );
   end

   // Clear only lands on the acked edge in ASSERT; a held ack cannot clear
   // a second request because HOLDOFF/IDLE ignore it.
   always_comb begin
      clear = '0;
      if (state_q == ST_ASSERT && i_ack) clear = id_onehot(irq_id_q);
   end

   // A new edge wins over a same-cycle clear: the event is kept and is not
   // an overrun, since the old one was just serviced.
   always_comb begin
      pending_d = (pending_q & ~clear) | rise;
      overrun_d = (i_ovr_clr ? '0 : overrun_q) | (rise & pending_q & ~clear);
   end

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      case (state_q)
         ST_IDLE: begin
            if (i_enc_valid) begin
               irq_id_d = i_enc_code;
               state_d  = ST_ASSERT;
            end
         end
         // id stays frozen regardless of new arrivals or mask changes
         ST_ASSERT:  if (i_ack) state_d = ST_HOLDOFF;
         // one dead cycle so the encoder sees the cleared pending vector
         ST_HOLDOFF: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q <= '0;
         overrun_q <= '0;
         irq_id_q  <= '0;
         state_q   <= ST_IDLE;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         irq_id_q  <= irq_id_d;
         state_q   <= state_d;
      end
   end

   assign o_code_req = pending_q & ~i_mask;
   assign o_pending  = pending_q;
   assign o_overrun  = overrun_q;
   assign o_irq      = (state_q == ST_ASSERT);
   assign o_irq_id   = irq_id_q;

endmodule

// File: tb/tb_irq_pending_4.sv
module tb_irq_pending_4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0, mask = '0;
   logic       ack = 1'b0, ovr_clr = 1'b0;
   logic [3:0] code_req, pending, overrun;
   logic [1:0] enc_code, irq_id;
   logic       enc_valid, irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_pending_4 #(.SYNC_STAGES(2)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_mask      (mask),
      .o_code_req  (code_req),
      .i_enc_code  (enc_code),
      .i_enc_valid (enc_valid),
      .o_irq       (irq),
      .o_irq_id    (irq_id),
      .i_ack       (ack),
      .o_pending   (pending),
      .o_overrun   (overrun),
      .i_ovr_clr   (ovr_clr)
   );

   // Stand-in for the downstream 4-to-2 priority encoder, bit 3 highest.
   always_comb begin
      enc_valid = |code_req;
      enc_code  = 2'd0;
      for (int i = 0; i < 4; i++) if (code_req[i]) enc_code = 2'(i);
   end

   // Behavioural model: samples[] remembers i_req at the last three edges; an
   // event becomes effective when it is two edges old and was low before.
   typedef struct packed {
      logic [3:0] pend;
      logic [3:0] ovr;
      logic       irq;
      logic [1:0] id;
      logic       cool;
      logic [3:0] s1, s2, s3;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t step(mstate_t c, logic [3:0] r, logic [3:0] mk,
                                    logic a, logic oc);
      mstate_t    n;
      logic [3:0] ev, clr, vis;
      n   = c;
      ev  = c.s2 & ~c.s3;
      clr = 4'b0;
      if (c.irq && a) clr[c.id] = 1'b1;
      vis = c.pend & ~mk;
      if (c.irq) begin
         if (a) begin n.irq = 1'b0; n.cool = 1'b1; end
      end else if (c.cool) begin
         n.cool = 1'b0;
      end else if (vis != 4'b0) begin
         n.irq = 1'b1;
         for (int i = 0; i < 4; i++) if (vis[i]) n.id = 2'(i);
      end
      n.ovr = oc ? 4'b0 : c.ovr;
      for (int k = 0; k < 4; k++) begin
         if (ev[k]) begin
            if (c.pend[k] && !clr[k]) n.ovr[k] = 1'b1;
            n.pend[k] = 1'b1;
         end else if (clr[k]) begin
            n.pend[k] = 1'b0;
         end
      end
      n.s3 = c.s2;
      n.s2 = c.s1;
      n.s1 = r;
      return n;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m, req, mask, ack, ovr_clr);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("m_irq", 8'(irq), 8'(m.irq));
      chk("m_pending", 8'(pending), 8'(m.pend));
      chk("m_overrun", 8'(overrun), 8'(m.ovr));
      chk("m_code_req", 8'(code_req), 8'(m.pend & ~mask));
      if (m.irq) chk("m_irq_id", 8'(irq_id), 8'(m.id));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_ack();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic drop();
      req = 4'b0; tick(4);
   endtask

   initial begin
      // reset state
      tick(2);
      chk("rst_irq", 8'(irq), 8'h0);
      chk("rst_irq_id", 8'(irq_id), 8'h0);
      chk("rst_pending", 8'(pending), 8'h0);
      chk("rst_overrun", 8'(overrun), 8'h0);
      chk("rst_code_req", 8'(code_req), 8'h0);
      rst_n = 1'b1;
      tick(2);

      // single request, latched on the 3rd edge
      req = 4'b0100;
      tick(2);
      chk("s1_pend_early", 8'(pending), 8'h0);
      tick();
      chk("s1_pend", 8'(pending), 8'h4);
      chk("s1_irq_lo", 8'(irq), 8'h0);
      tick();
      chk("s1_irq", 8'(irq), 8'h1);
      chk("s1_id", 8'(irq_id), 8'h2);
      pulse_ack();
      chk("s1_pend_clr", 8'(pending), 8'h0);
      chk("s1_irq_drop", 8'(irq), 8'h0);
      tick(4);
      chk("s1_no_irq", 8'(irq), 8'h0);
      drop();

      // priority and hold
      req = 4'b1001;
      tick(4);
      chk("s2_id3", 8'(irq_id), 8'h3);
      pulse_ack();
      chk("s2_holdoff", 8'(irq), 8'h0);
      tick();
      chk("s2_idle", 8'(irq), 8'h0);
      tick();
      chk("s2_irq0", 8'(irq), 8'h1);
      chk("s2_id0", 8'(irq_id), 8'h0);
      req = 4'b0001;
      tick(3);
      req = 4'b1001;
      tick(3);
      chk("s2_pend9", 8'(pending), 8'h9);
      chk("s2_id0_held", 8'(irq_id), 8'h0);
      pulse_ack();
      tick(2);
      chk("s2_id3_again", 8'(irq_id), 8'h3);
      chk("s2_irq3", 8'(irq), 8'h1);
      pulse_ack();
      drop();

      // mask
      mask = 4'b1000;
      req  = 4'b1010;
      tick(3);
      chk("s3_code", 8'(code_req), 8'h2);
      tick();
      chk("s3_id1", 8'(irq_id), 8'h1);
      pulse_ack();
      tick(3);
      chk("s3_no_irq", 8'(irq), 8'h0);
      chk("s3_pend8", 8'(pending), 8'h8);
      mask = 4'b0000;
      #1;
      chk("s3_code_unmask", 8'(code_req), 8'h8);
      tick();
      chk("s3_id3", 8'(irq_id), 8'h3);
      chk("s3_irq", 8'(irq), 8'h1);
      pulse_ack();
      drop();

      // overrun
      req = 4'b0100;
      tick(4);
      chk("s4_id2", 8'(irq_id), 8'h2);
      req = 4'b0000;
      tick(3);
      req = 4'b0100;
      tick(3);
      chk("s4_ovr", 8'(overrun), 8'h4);
      chk("s4_pend", 8'(pending), 8'h4);
      pulse_ack();
      chk("s4_ovr_sticky", 8'(overrun), 8'h4);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("s4_ovr_clr", 8'(overrun), 8'h0);
      drop();

      // set/clear collision
      req = 4'b0010;
      tick(4);
      chk("s5_id1", 8'(irq_id), 8'h1);
      req = 4'b0000;
      tick(3);
      req = 4'b0010;
      tick(2);
      pulse_ack();
      chk("s5_pend_kept", 8'(pending), 8'h2);
      chk("s5_no_ovr", 8'(overrun), 8'h0);
      tick(2);
      chk("s5_irq_again", 8'(irq), 8'h1);
      chk("s5_id1_again", 8'(irq_id), 8'h1);
      pulse_ack();
      drop();

      // reset mid-handshake
      req = 4'b1000;
      tick(4);
      chk("s6_irq", 8'(irq), 8'h1);
      rst_n = 1'b0;
      #1;
      chk("s6_rst_irq", 8'(irq), 8'h0);
      chk("s6_rst_pend", 8'(pending), 8'h0);
      chk("s6_rst_ovr", 8'(overrun), 8'h0);
      chk("s6_rst_code", 8'(code_req), 8'h0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("s6_pend_early", 8'(pending), 8'h0);
      tick();
      chk("s6_relatch", 8'(pending), 8'h8);
      tick();
      chk("s6_irq_again", 8'(irq_id), 8'h3);
      pulse_ack();
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_pending_4.md
Name: irq_pending_4

Overview:
Request-capture stage directly upstream of the 4-to-2 priority encoder.
- Synchronises four asynchronous request lines and latches their rising edges into sticky pending bits.
- Drives the unmasked pending vector into the encoder's i_code.
- Consumes the encoder's o_code/o_valid and runs an irq/ack handshake that clears the serviced pending bit.

Parameters:
N_REQ, 4, number of request lines (the encoder is 4-input, so only 4 is supported)
CODE_W, 2, width of the encoded request id
SYNC_STAGES, 2, flops in each input synchroniser (minimum 2)

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  4  asynchronous request lines; a rising edge is an event
i_mask  in  4  1 = suppress the bit toward the encoder (pending still latches)
o_code_req  out  4  pending & ~i_mask; connects to the encoder's i_code
i_enc_code  in  2  encoder o_code
i_enc_valid  in  1  encoder o_valid
o_irq  out  1  interrupt asserted to the consumer
o_irq_id  out  2  id of the request being serviced; stable while o_irq=1
i_ack  in  1  consumer acknowledge, one-cycle pulse
o_pending  out  4  raw pending register
o_overrun  out  4  sticky: an edge arrived while that bit was already pending
i_ovr_clr  in  1  one-cycle pulse; clears all o_overrun bits

Behaviour:
- Reset (i_rst_n=0, asynchronous): synchroniser flops, edge-history register, pending, overrun and FSM all go to 0.
  - Outputs during reset: o_irq=0, o_irq_id=0, o_pending=0, o_overrun=0, o_code_req=0.
- Requests held high through reset deassertion: history is 0, so each such request is detected as a new edge and latched.
- Edge detection: SYNC_STAGES flops per bit, then rise = sync_out & ~hist.
  - With SYNC_STAGES=2, pending[k] is set on the 3rd rising edge of i_clk counting the first edge that samples i_req[k]=1.
  - i_req high pulses shorter than one clock period may be lost; this is not required behaviour.
  - A held-high request produces exactly one event.
- Pending update per bit k, each clock:
  - if rise[k]: pending[k] <= 1.
  - else if clear[k]: pending[k] <= 0.
  - Set wins over a same-cycle clear. The new event is retained and overrun is not set.
- Overrun: rise[k] & pending[k] & ~clear[k] sets overrun[k].
  - i_ovr_clr clears all bits.
  - If the set and the clear coincide, set wins.
- o_code_req is combinational from the pending register and i_mask. There are no other combinational paths from inputs to outputs.
- Encoder: combinational, bit 3 highest priority. i_enc_code/i_enc_valid are sampled in the same cycle as o_code_req.
- FSM has three states, encoded in the package:
  - IDLE: o_irq=0. If i_enc_valid, then o_irq_id <= i_enc_code and go to ASSERT; o_irq rises the next cycle.
  - ASSERT: o_irq=1 and o_irq_id is frozen. Higher-priority arrivals and mask changes (including masking o_irq_id) do not retract or change the irq.
    - On i_ack=1: clear[o_irq_id] is asserted for this edge; go to HOLDOFF.
  - HOLDOFF: o_irq=0 for exactly one cycle; i_ack is ignored; go to IDLE. This gives the encoder one cycle to see the updated pending vector.
- i_ack is ignored in IDLE and HOLDOFF. A held i_ack therefore clears at most one request per handshake.
- Minimum spacing between successive irq assertions is 3 cycles: ASSERT(ack), HOLDOFF, IDLE, then ASSERT.
- Reset asserted mid-handshake: o_irq drops immediately and the pending request is discarded.

Decomposition:
- Package irq_pkg holds:
  - N_REQ and CODE_W.
  - FSM state localparams: ST_IDLE=2'b00, ST_ASSERT=2'b01, ST_HOLDOFF=2'b10. 2'b11 recovers to ST_IDLE.
- Sub-module sync_edge_det: one bit wide, with parameter SYNC_STAGES, ports i_clk, i_rst_n, i_async, o_rise. Instantiate it 4 times via generate.
- The priority encoder is NOT inside this block. The bench connects the existing encoder between o_code_req and i_enc_code/i_enc_valid.

Test Plan:
- Reset and single request: release reset with i_req=0, then raise i_req=4'b0100.
  - 3 cycles later o_pending=4'b0100; next cycle o_irq=1, o_irq_id=2.
  - Pulse i_ack: o_pending=0, o_irq=0, and no further irq.
- Priority and hold: raise i_req bit 0, and bit 3 in the same cycle.
  - o_irq_id=3 first; after ack, HOLDOFF, IDLE, then o_irq_id=0.
  - Bit 3 rising after irq id 0 is asserted must not change o_irq_id.
- Mask: i_mask=4'b1000, raise bits 3 and 1.
  - o_code_req=4'b0010 and the irq is serviced with id=1. o_pending[3] stays 1.
  - Unmasking bit 3 causes irq id=3.
- Overrun: bit 2 pending and unacked, produce a second edge on i_req[2].
  - o_overrun=4'b0100 and a single pending bit remains.
  - i_ovr_clr gives o_overrun=0.
- Set/clear collision: time a new edge on bit 1 so that rise[1] coincides with the i_ack edge for id 1.
  - o_pending[1] stays 1, o_overrun[1]=0, and a second irq with id=1 follows.
- Reset mid-operation: assert i_rst_n=0 while o_irq=1.
  - o_irq, o_pending and o_overrun go to 0 immediately, without a clock.
  - With i_req held high at release, the request is re-latched after 3 cycles.
